// File: rtl/tlcd_pkg.sv
// Shared Text LCD definitions: bus arbiter FSM encoding, HD44780 timing
// constants (used by tlcd_controller and custom_font_loader) and small
// width helpers.
package tlcd_pkg;

    // Bus arbiter states.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_e;

    // HD44780 timing, in cycles of a 50 MHz system clock.
    localparam int unsigned HD_POWER_ON_CYCLES = 750_000; // 15 ms after Vcc rise
    localparam int unsigned HD_E_PULSE_CYCLES  = 12;      // >= 230 ns E high
    localparam int unsigned HD_CMD_CYCLES      = 1_850;   // 37 us typical command
    localparam int unsigned HD_CLEAR_CYCLES    = 76_000;  // 1.52 ms clear/home

    // Bits needed to index NREQ requesters (at least one).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold the value max_val (at least one).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/tlcd_arb_pick.sv
// Combinational winner search: returns the first asserted request at or
// after start_idx, wrapping around to index 0.
module tlcd_arb_pick
    import tlcd_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] start_idx,
    output logic [NREQ-1:0]  gnt_oh,
    output logic             valid
);

    // Two passes: indices >= start first, then the wrapped-around remainder.
    always_comb begin
        gnt_oh = '0;
        valid  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i] && (IDX_W'(i) >= start_idx)) begin
                gnt_oh[i] = 1'b1;
                valid     = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i]) begin
                gnt_oh[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlcd_bus_arbiter.sv
// Text LCD pin-bus arbiter. Grants one writer at a time (font loader = req 0,
// text renderer = req 1), passes its E/RS/RW/DATA straight to the pins,
// inserts an E-low gap between owners and reclaims the bus from an owner
// that holds it for TIMEOUT cycles.
// Build option: define TLCD_ARB_RR_EN for round-robin arbitration; by
// default the lowest asserted index wins.
module tlcd_bus_arbiter
    import tlcd_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned GAP_CYCLES = 50,
    parameter int unsigned TIMEOUT    = 400000
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ-1:0]   REQ_E,
    input  logic [NREQ-1:0]   REQ_RS,
    input  logic [NREQ-1:0]   REQ_RW,
    input  logic [8*NREQ-1:0] REQ_DATA,
    output logic [NREQ-1:0]   GNT,
    output logic              BUSY,
    output logic              TIMEOUT_ERR,
    output logic              TLCD_E,
    output logic              TLCD_RS,
    output logic              TLCD_RW,
    output logic [7:0]        TLCD_DATA
);

    localparam int unsigned IDX_W  = idx_width(NREQ);
    localparam int unsigned HOLD_W = cnt_width(TIMEOUT);
    localparam int unsigned GAP_W  = cnt_width(GAP_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              err_q, err_d;
    logic              last_rs_q, last_rs_d;
    logic              last_rw_q, last_rw_d;
    logic [7:0]        last_data_q, last_data_d;

    logic [IDX_W-1:0]  start_idx;
    logic [NREQ-1:0]   pick_oh;
    logic              pick_valid;
    logic              owner_req;
    logic              sel_e, sel_rs, sel_rw;
    logic [7:0]        sel_data;

    tlcd_arb_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (REQ),
        .start_idx (start_idx),
        .gnt_oh    (pick_oh),
        .valid     (pick_valid)
    );

`ifdef TLCD_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Search begins just after the last grantee, wrapping NREQ-1 -> 0.
    always_comb begin
        start_idx = (ptr_q == IDX_W'(NREQ - 1)) ? '0 : ptr_q + 1'b1;
        ptr_d     = ptr_q;
        if (state_q == ARB_IDLE && pick_valid) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pick_oh[i]) ptr_d = IDX_W'(i);
            end
        end
    end

    // Last-grantee pointer; resets to NREQ-1 so the first search starts at 0.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) ptr_q <= IDX_W'(NREQ - 1);
        else         ptr_q <= ptr_d;
    end
`else
    assign start_idx = '0;
`endif

    // Only the granted requester reaches the pins; gnt_q is one-hot or zero.
    always_comb begin
        sel_e    = 1'b0;
        sel_rs   = 1'b0;
        sel_rw   = 1'b0;
        sel_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                sel_e    = REQ_E[i];
                sel_rs   = REQ_RS[i];
                sel_rw   = REQ_RW[i];
                sel_data = REQ_DATA[8*i +: 8];
            end
        end
    end

    assign owner_req = |(REQ & gnt_q);

    // Next-state and counter logic for IDLE -> GRANT -> GAP -> IDLE.
    // NOTE: every always_comb target gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        err_d       = err_q;
        last_rs_d   = last_rs_q;
        last_rw_d   = last_rw_q;
        last_data_d = last_data_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_GRANT;
                    gnt_d   = pick_oh;
                    hold_d  = '0;
                end
            end
            ARB_GRANT: begin
                last_rs_d   = sel_rs;
                last_rw_d   = sel_rw;
                last_data_d = sel_data;
                if (!owner_req || hold_q == HOLD_LAST) begin
                    // Still requesting at the limit means the watchdog fired.
                    if (owner_req) err_d = 1'b1;
                    gnt_d   = '0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ARB_GAP: begin
                if (gap_q == GAP_LAST) state_d = ARB_IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, grant, counters, sticky error and last-driven pin values.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            hold_q      <= '0;
            gap_q       <= '0;
            err_q       <= 1'b0;
            last_rs_q   <= 1'b0;
            last_rw_q   <= 1'b0;
            last_data_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            hold_q      <= hold_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
            last_rs_q   <= last_rs_d;
            last_rw_q   <= last_rw_d;
            last_data_q <= last_data_d;
        end
    end

    // Pin drive: owner pass-through, E forced low in GAP, quiet bus in IDLE.
    always_comb begin
        TLCD_E    = 1'b0;
        TLCD_RS   = 1'b0;
        TLCD_RW   = 1'b0;
        TLCD_DATA = 8'h00;
        case (state_q)
            ARB_GRANT: begin
                TLCD_E    = sel_e;
                TLCD_RS   = sel_rs;
                TLCD_RW   = sel_rw;
                TLCD_DATA = sel_data;
            end
            ARB_GAP: begin
                TLCD_RS   = last_rs_q;
                TLCD_RW   = last_rw_q;
                TLCD_DATA = last_data_q;
            end
            default: ;
        endcase
    end

    assign GNT         = gnt_q;
    assign BUSY        = (state_q != ARB_IDLE);
    assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_tlcd_bus_arbiter.sv
// Self-checking bench for tlcd_bus_arbiter: directed scenarios followed by
// random request traffic, checked against a behavioural model of the bus
// ownership rules. Grant events go through a scoreboard queue.
module tb_tlcd_bus_arbiter;

    localparam int NREQ = 2;
    localparam int GAP  = 50;
    localparam int TMO  = 100;
`ifdef TLCD_ARB_RR_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RESETN = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_e = '0;
    logic [NREQ-1:0]   req_rs = '0;
    logic [NREQ-1:0]   req_rw = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   gnt;
    logic              busy, terr, lcd_e, lcd_rs, lcd_rw;
    logic [7:0]        lcd_data;

    always #5 CLK = ~CLK;

    tlcd_bus_arbiter #(
        .NREQ       (NREQ),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .REQ         (req),
        .REQ_E       (req_e),
        .REQ_RS      (req_rs),
        .REQ_RW      (req_rw),
        .REQ_DATA    (req_data),
        .GNT         (gnt),
        .BUSY        (busy),
        .TIMEOUT_ERR (terr),
        .TLCD_E      (lcd_e),
        .TLCD_RS     (lcd_rs),
        .TLCD_RW     (lcd_rw),
        .TLCD_DATA   (lcd_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mode [NREQ];            // 0 random pins, 1 steady 8'h38 with E toggling, 2 hostile E=1/FF

    // Reference model: who owns the bus, for how long, and how much gap is left.
    int         m_owner;        // -1 when nobody owns the bus
    int         m_held;
    int         m_gap_left;
    int         m_last;
    bit         m_err;
    logic       m_lrs, m_lrw;
    logic [7:0] m_ldata;
    int         exp_grant_q[$];
    int         dut_seq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int arb_pick(input logic [NREQ-1:0] r, input int last);
        int start;
        int c;
        start = 0;
        if (ROUND_ROBIN) start = (last + 1) % NREQ;
        for (int k = 0; k < NREQ; k++) begin
            c = (start + k) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (!RESETN) begin
            m_owner    = -1;
            m_held     = 0;
            m_gap_left = 0;
            m_last     = NREQ - 1;
            m_err      = 1'b0;
            m_lrs      = 1'b0;
            m_lrw      = 1'b0;
            m_ldata    = 8'h00;
            exp_grant_q.delete();
        end else if (m_owner >= 0) begin
            m_lrs   = req_rs[m_owner];
            m_lrw   = req_rw[m_owner];
            m_ldata = req_data[8*m_owner +: 8];
            m_held++;
            if (!req[m_owner] || m_held == TMO) begin
                if (req[m_owner]) m_err = 1'b1;
                m_owner    = -1;
                m_gap_left = GAP;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else begin
            w = arb_pick(req, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 0;
                m_last  = w;
                exp_grant_q.push_back(w);
            end
        end
    endtask

    // Model advances on every clock edge and immediately on reset assertion.
    initial begin
        model_step();
        forever begin
            @(posedge CLK or negedge RESETN);
            model_step();
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Requester pin activity, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                case (mode[i])
                    1: begin
                        req_e[i] = ~req_e[i];
                        req_rs[i] = 1'b0;
                        req_rw[i] = 1'b0;
                        req_data[8*i +: 8] = 8'h38;
                    end
                    2: begin
                        req_e[i] = 1'b1;
                        req_rs[i] = 1'b1;
                        req_rw[i] = 1'b1;
                        req_data[8*i +: 8] = 8'hFF;
                    end
                    default: begin
                        req_e[i] = 1'($urandom);
                        req_rs[i] = 1'($urandom);
                        req_rw[i] = 1'($urandom);
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                endcase
            end
        end
    end

    // Monitor: compares every cycle on the falling edge and pops the grant
    // scoreboard whenever the DUT presents a new grant.
    initial begin
        logic [NREQ-1:0] prev_gnt;
        logic [NREQ-1:0] e_gnt;
        logic [11:0]     e_pins;
        int              idx;
        prev_gnt = '0;
        forever begin
            @(negedge CLK);
            e_gnt  = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
            if (m_owner >= 0)
                e_pins = {req_e[m_owner], req_rs[m_owner], req_rw[m_owner], req_data[8*m_owner +: 8]};
            else if (m_gap_left > 0)
                e_pins = {1'b0, m_lrs, m_lrw, m_ldata};
            else
                e_pins = '0;
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("busy_err", {30'd0, busy, terr}, {30'd0, (m_owner >= 0 || m_gap_left > 0), m_err});
            check("pins", {20'd0, lcd_e, lcd_rs, lcd_rw, lcd_data}, {20'd0, e_pins});
            if (gnt != '0 && prev_gnt == '0) begin
                idx = -1;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
                dut_seq.push_back(idx);
                if (exp_grant_q.size() == 0) check("grant_unexpected", 32'(idx), 32'hFFFF_FFFF);
                else                         check("grant_event", 32'(idx), 32'(exp_grant_q.pop_front()));
            end
            prev_gnt = gnt;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int exp_seq [4];
        int hold_cnt [NREQ];
        int target [NREQ];
        for (int i = 0; i < NREQ; i++) begin
            mode[i] = 0;
            hold_cnt[i] = 0;
            target[i] = 1;
        end
        if (ROUND_ROBIN) exp_seq = '{0, 1, 0, 1};
        else             exp_seq = '{0, 0, 0, 0};

        // 1. Reset with both requesting, then first grant one cycle after release.
        req = 2'b11;
        tick(3);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_pins", {23'd0, lcd_e, lcd_data}, 32'd0);
        RESETN = 1'b1;
        tick(1);
        check("first_grant", 32'(gnt), 32'h1);
        tick(4);
        req = 2'b00;
        tick(60);

        // 2. req0 holds with DATA=8'h38 and E toggling; req1 waits out the gap.
        req[0] = 1'b1;
        mode[0] = 1;
        tick(3);
        req[1] = 1'b1;
        tick(8);
        req[0] = 1'b0;
        mode[0] = 0;
        tick(GAP + 3);
        check("after_gap_grant", 32'(gnt), 32'h2);
        tick(5);
        req[1] = 1'b0;
        tick(60);

        // 3. No pre-emption; non-granted req0 drives hostile pins.
        req[1] = 1'b1;
        tick(5);
        req[0] = 1'b1;
        mode[0] = 2;
        tick(10);
        check("no_preempt", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        tick(GAP + 3);
        check("waiter_granted", 32'(gnt), 32'h1);
        mode[0] = 0;
        tick(5);
        req[0] = 1'b0;
        tick(60);

        // 4. Watchdog: req1 never releases within TIMEOUT.
        req[1] = 1'b1;
        tick(TMO + 2);
        check("timeout_err_set", {30'd0, terr, |gnt}, 32'h2);
        tick(20);
        req[1] = 1'b0;
        tick(GAP);
        req[0] = 1'b1;
        tick(5);
        req[0] = 1'b0;
        tick(60);
        check("timeout_err_sticky", 32'(terr), 32'h1);

        // 5. Reset mid-grant, then both requesting continuously for 4 grants.
        req[1] = 1'b1;
        tick(5);
        RESETN = 1'b0;
        #1;
        check("reset_drops_grant", {30'd0, terr, |gnt}, 32'd0);
        req = 2'b11;
        tick(2);
        RESETN = 1'b1;
        dut_seq.delete();
        tick(4 * (TMO + GAP) + 20);
        check("arb_grant_count", 32'(dut_seq.size() >= 4), 32'h1);
        for (int k = 0; k < 4; k++) begin
            if (dut_seq.size() > k) check("arb_order", 32'(dut_seq[k]), 32'(exp_seq[k]));
        end
        req = 2'b00;
        tick(TMO + GAP + 10);

        // 6. Random traffic: requesters hold REQ for a random number of granted cycles.
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req[i] = 1'b1;
                        hold_cnt[i] = 0;
                        target[i] = ($urandom_range(0, 9) == 0) ? TMO + 30 : $urandom_range(1, 40);
                    end
                end else if (m_owner == i) begin
                    hold_cnt[i]++;
                    if (hold_cnt[i] >= target[i]) req[i] = 1'b0;
                end
            end
            tick(1);
        end
        req = '0;
        tick(TMO + GAP + 10);
        check("grant_queue_drained", 32'(exp_grant_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
